// File: rtl/mem_copy_master_if.sv
// Memory bus between the copy master and its responder: valid/ready handshake,
// byte strobes selecting read (0000) or write (1111).
interface mem_copy_master_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_wstrb, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_copy_master.sv
// Word-by-word memory copy engine: read one word, write it, repeat, with a
// per-transaction ready timeout that aborts the copy and raises a sticky error.
module mem_copy_master #(
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [31:0]               src_addr,
  input  logic [31:0]               dst_addr,
  input  logic [15:0]               count,
  input  logic                      src_fixed,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  mem_copy_master_if.master         bus
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FINISH} state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  state_t      state, next_state;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] rem_q, rem_d;
  logic        fixed_q, fixed_d;
  logic [31:0] data_q, data_d;
  logic [15:0] tcnt_q;
  logic        timeout_hit;

  assign bus.mem_instr = 1'b0;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state  = state;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    fixed_d     = fixed_q;
    data_d      = data_q;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          src_d      = src_addr & 32'hFFFF_FFFC;
          dst_d      = dst_addr & 32'hFFFF_FFFC;
          rem_d      = count;
          fixed_d    = src_fixed;
          next_state = (count == 16'd0) ? FINISH : RD_REQ;
        end
      end
      RD_REQ: begin
        if (bus.mem_ready) begin
          data_d     = bus.mem_rdata;
          next_state = RD_GAP;
        end else if (tcnt_q == TMAX) begin
          timeout_hit = 1'b1;
          next_state  = FINISH;
        end
      end
      RD_GAP: next_state = WR_REQ;
      WR_REQ: begin
        if (bus.mem_ready) begin
          rem_d = rem_q - 16'd1;
          dst_d = dst_q + 32'd4;
          if (!fixed_q) src_d = src_q + 32'd4;
          next_state = WR_GAP;
        end else if (tcnt_q == TMAX) begin
          timeout_hit = 1'b1;
          next_state  = FINISH;
        end
      end
      WR_GAP: next_state = (rem_q != 16'd0) ? RD_REQ : FINISH;
      FINISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus outputs are registered from next_state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      src_q         <= '0;
      dst_q         <= '0;
      rem_q         <= '0;
      fixed_q       <= 1'b0;
      data_q        <= '0;
      tcnt_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.mem_wstrb <= 4'b0000;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      src_q         <= src_d;
      dst_q         <= dst_d;
      rem_q         <= rem_d;
      fixed_q       <= fixed_d;
      data_q        <= data_d;
      busy          <= (next_state != IDLE);
      done          <= (state == FINISH);
      bus.mem_valid <= (next_state == RD_REQ) || (next_state == WR_REQ);
      bus.mem_wstrb <= (next_state == WR_REQ) ? 4'b1111 : 4'b0000;

      if (state == IDLE && start) error <= 1'b0;
      else if (timeout_hit)      error <= 1'b1;

      if (next_state == RD_REQ && state != RD_REQ) bus.mem_addr <= src_d;
      if (next_state == WR_REQ && state != WR_REQ) begin
        bus.mem_addr  <= dst_d;
        bus.mem_wdata <= data_d;
      end

      // Counts wait cycles of the current request; restarts on every state change.
      if (next_state != state)                     tcnt_q <= '0;
      else if (state == RD_REQ || state == WR_REQ) tcnt_q <= tcnt_q + 16'd1;
    end
  end

endmodule
